// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, Start/Done handshake.
// Optional macro DIV_SIGNED_EN selects two's-complement operands with a sign fix-up cycle.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd;
  logic [CW-1:0]    cnt;
  logic             dz;
`ifdef DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  logic             accept;
  logic             last;
  logic [WIDTH:0]   r_shift;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign accept = Start && ((state == IDLE) || (state == FIN));
  assign last   = (cnt == CW'(WIDTH - 1));

  // The restored remainder is always below the divisor, so WIDTH bits of storage
  // suffice; only the shifted trial value needs the extra bit.
  assign r_shift = {r_sh, q_sh[WIDTH-1]};
  assign ge      = (r_shift >= {1'b0, dvs});
  assign r_step  = ge ? WIDTH'(r_shift - {1'b0, dvs}) : r_shift[WIDTH-1:0];
  assign q_step  = {q_sh[WIDTH-2:0], ge};

  assign Busy = (state == RUN) || (state == FIX);
  assign Done = (state == FIN);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // A zero divisor still spends one busy cycle in RUN so Done lands after E+1.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN: begin
        if (dz) state_n = FIN;
        else if (last) begin
`ifdef DIV_SIGNED_EN
          state_n = FIX;
`else
          state_n = FIN;
`endif
        end
      end
      FIX:     state_n = FIN;
      FIN:     state_n = accept ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_sh  <= '0;
      r_sh  <= '0;
      dvs   <= '0;
      dvd   <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (accept) begin
      dvd <= Dividend;
      dz  <= (Divisor == '0);
      cnt <= '0;
      r_sh <= '0;
`ifdef DIV_SIGNED_EN
      q_sh  <= Dividend[WIDTH-1] ? -Dividend : Dividend;
      dvs   <= Divisor[WIDTH-1]  ? -Divisor  : Divisor;
      neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
      neg_r <= Dividend[WIDTH-1];
`else
      q_sh <= Dividend;
      dvs  <= Divisor;
`endif
    end else if ((state == RUN) && !dz) begin
      q_sh <= q_step;
      r_sh <= r_step;
      cnt  <= cnt + 1'b1;
    end
  end

  // Results move only on the edge that enters FIN; they hold through the next division.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else if ((state == RUN) && dz) begin
      Quotient  <= '1;
      Remainder <= dvd;
      DivByZero <= 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (state == FIX) begin
        Quotient  <= neg_q ? -q_sh : q_sh;
        Remainder <= neg_r ? -r_sh : r_sh;
        DivByZero <= 1'b0;
      end
`else
      if ((state == RUN) && last) begin
        Quotient  <= q_step;
        Remainder <= r_step;
        DivByZero <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (unsigned build, WIDTH=4).
module tb_seq_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [3:0] Dividend, Divisor;
  logic       Busy, Done, DivByZero;
  logic [3:0] Quotient, Remainder;

  int n_chk  = 0;
  int n_pass = 0;
  int hold_bad = 0;
  int lat;
  logic [8:0] prev;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done),
    .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called #1 after a rising edge. Operands are scrambled after the accept edge,
  // and optional Start pulses are injected mid-run; neither may disturb the result.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b, input bit inj,
                         output int l, output logic acc_busy);
    Dividend = a; Divisor = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Dividend = ~a; Divisor = ~b;
    acc_busy = Busy;
    l = 0;
    while (!Done && l < 40) begin
      Start = inj && (l == 1 || l == 2);
      if (Start) begin Dividend = 4'hf; Divisor = 4'h1; end
      @(posedge Clk); #1;
      l++;
      if (!Done && {DivByZero, Quotient, Remainder} !== prev) hold_bad++;
    end
    Start = 1'b0;
    prev = {DivByZero, Quotient, Remainder};
  endtask

  initial begin
    logic ab;
    logic [3:0] eq, er;
    int el;
    Reset_n = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
    prev = '0;
    #2;
    chk("reset_out", {Busy, Done, DivByZero, Quotient, Remainder}, 11'h0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;

    // 13/3
    run_div(4'd13, 4'd3, 1'b0, lat, ab);
    chk("13/3 busy_at_accept", ab, 1);
    chk("13/3 latency", lat, 4);
    chk("13/3 result", {DivByZero, Quotient, Remainder}, {1'b0, 4'd4, 4'd1});
    chk("13/3 done_busy", {Done, Busy}, 2'b10);
    @(posedge Clk); #1;
    chk("13/3 done_one_cycle", {Done, Busy}, 2'b00);
    chk("13/3 held", {DivByZero, Quotient, Remainder}, {1'b0, 4'd4, 4'd1});
    @(posedge Clk); #1;

    // divide by zero then recovery
    run_div(4'd5, 4'd0, 1'b0, lat, ab);
    chk("5/0 latency", lat, 1);
    chk("5/0 result", {DivByZero, Quotient, Remainder}, {1'b1, 4'd15, 4'd5});
    @(posedge Clk); #1;
    chk("5/0 held", {DivByZero, Quotient, Remainder}, {1'b1, 4'd15, 4'd5});
    run_div(4'd15, 4'd1, 1'b0, lat, ab);
    chk("15/1 latency", lat, 4);
    chk("15/1 result", {DivByZero, Quotient, Remainder}, {1'b0, 4'd15, 4'd0});
    @(posedge Clk); #1;

    // 2/7 with Start pulses during RUN, then back-to-back 9/9 from the Done cycle
    run_div(4'd2, 4'd7, 1'b1, lat, ab);
    chk("2/7 latency", lat, 4);
    chk("2/7 result", {DivByZero, Quotient, Remainder}, {1'b0, 4'd0, 4'd2});
    chk("2/7 done", Done, 1);
    run_div(4'd9, 4'd9, 1'b0, lat, ab);
    chk("9/9 b2b busy_at_accept", ab, 1);
    chk("9/9 b2b latency", lat, 4);
    chk("9/9 result", {DivByZero, Quotient, Remainder}, {1'b0, 4'd1, 4'd0});
    @(posedge Clk); #1;

    // asynchronous reset after two iterations
    Dividend = 4'd12; Divisor = 4'd5; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    chk("pre_reset busy", Busy, 1);
    Reset_n = 1'b0; #1;
    chk("mid_run_reset", {Busy, Done, DivByZero, Quotient, Remainder}, 11'h0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    prev = '0;
    run_div(4'd6, 4'd4, 1'b0, lat, ab);
    chk("6/4 latency", lat, 4);
    chk("6/4 result", {DivByZero, Quotient, Remainder}, {1'b0, 4'd1, 4'd2});

    // all operand pairs, with an idle cycle after every odd divisor
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        el = (b == 0) ? 1 : 4;
        run_div(4'(a), 4'(b), 1'b0, lat, ab);
        chk($sformatf("exh %0d/%0d", a, b),
            {lat[7:0], DivByZero, Quotient, Remainder},
            {el[7:0], (b == 0), eq, er});
        if (b % 2 == 1) begin
          @(posedge Clk); #1;
          if (Done || Busy) hold_bad++;
        end
      end
    end
    chk("hold_between_done", hold_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
